// File: rtl/seg7_scan_bcd.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_bcd
// Brief    : Latches packed BCD, scans digits with a fixed dwell, drives
//            active-low segment/anode pins with leading-zero blanking.
// Revision : 1.0  initial release
// ============================================================================
module seg7_scan_bcd #(
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                CLK,
  input  logic                CLR_N,
  input  logic [4*DIGITS-1:0] D,
  input  logic                LD,
  output logic [6:0]          SEG,
  output logic [DIGITS-1:0]   AN,
  output logic                ERR
);

  localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DIGITS - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE   = c_IDX_W'(1);
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DIV_W-1:0] c_DIV_ONE   = c_DIV_W'(1);
  localparam logic [6:0]         c_SEG_BLANK = 7'h7F;
  localparam logic [6:0]         c_SEG_DASH  = 7'h3F;

  logic [4*DIGITS-1:0] r_latch;
  logic [c_DIV_W-1:0]  r_div;
  logic [c_IDX_W-1:0]  r_idx;
  logic [6:0]          r_seg;
  logic [DIGITS-1:0]   r_an;
  logic                r_err;

  logic [3:0]          w_nib [DIGITS];
  logic [DIGITS-1:0]   w_nonbcd;
  logic [DIGITS-1:0]   w_zero_from;
  logic [DIGITS-1:0]   w_an_onehot;
  logic [3:0]          w_cur_nib;
  logic                w_cur_blank;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = c_SEG_DASH;
    endcase
    return seg;
  endfunction

  genvar gi;
  for (gi = 0; gi < DIGITS; gi++) begin : g_nib
    assign w_nib[gi]    = r_latch[4*gi +: 4];
    assign w_nonbcd[gi] = (r_latch[4*gi +: 4] > 4'd9);
  end

  // w_zero_from[i] is set when nibbles i..DIGITS-1 are all zero; non-BCD counts as non-zero
  always_comb begin
    w_zero_from = '0;
    w_zero_from[DIGITS-1] = (w_nib[DIGITS-1] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      w_zero_from[i] = (w_nib[i] == 4'd0) && w_zero_from[i+1];
    end
  end

  always_comb begin
    w_cur_nib          = w_nib[r_idx];
    w_cur_blank        = BLANK_LZ && (r_idx != '0) && w_zero_from[r_idx];
    w_an_onehot        = '1;
    w_an_onehot[r_idx] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_latch <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_seg   <= c_SEG_BLANK;
      r_an    <= '1;
      r_err   <= 1'b0;
    end else begin
      if (LD) begin
        r_latch <= D;
      end
      if (r_div == c_DIV_LAST) begin
        r_div <= '0;
        r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_ONE;
      end else begin
        r_div <= r_div + c_DIV_ONE;
      end
      // Outputs follow the pre-edge idx, so a new digit appears one edge after idx moves
      r_an  <= w_cur_blank ? '1 : w_an_onehot;
      r_seg <= w_cur_blank ? c_SEG_BLANK : f_decode(w_cur_nib);
      r_err <= |w_nonbcd;
    end
  end

  assign SEG = r_seg;
  assign AN  = r_an;
  assign ERR = r_err;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_bcd.sv
`default_nettype none
// Directed self-checking bench for seg7_scan_bcd (two digits, dwell of 4),
// with a second instance that has leading-zero blanking disabled.
module tb_seg7_scan_bcd;

  logic       CLK = 1'b0;
  logic       CLR_N;
  logic [7:0] D;
  logic       LD;
  logic [6:0] SEG, SEG_NB;
  logic [1:0] AN, AN_NB;
  logic       ERR, ERR_NB;

  int checks    = 0;
  int errors    = 0;
  int rel_edges = 0;
  int cur       = 0;
  int dig       = 0;

  logic [6:0] seg_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  always #5 CLK = ~CLK;

  seg7_scan_bcd #(.DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .CLK(CLK), .CLR_N(CLR_N), .D(D), .LD(LD), .SEG(SEG), .AN(AN), .ERR(ERR)
  );

  seg7_scan_bcd #(.DIGITS(2), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
    .CLK(CLK), .CLR_N(CLR_N), .D(D), .LD(LD), .SEG(SEG_NB), .AN(AN_NB), .ERR(ERR_NB)
  );

  // One clock edge; afterwards cur is the edge number since reset release and
  // dig is the digit the outputs of that edge must show.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = !CLR_N;
    @(posedge CLK);
    #1;
    if (rst_at_edge) begin
      rel_edges = 0;
      cur       = -1;
      dig       = 0;
    end else begin
      cur       = rel_edges;
      rel_edges = rel_edges + 1;
      dig       = (cur / 4) % 2;
    end
  endtask

  task automatic test_reset();
    logic [1:0] ean;
    logic [6:0] eseg;
    CLR_N = 1'b0; LD = 1'b0; D = 8'h00;
    repeat (5) begin
      tick();
      checks++;
      if (AN !== 2'b11 || SEG !== 7'h7F || ERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: AN=%b SEG=%h ERR=%b expected AN=11 SEG=7f ERR=0", AN, SEG, ERR);
      end
    end
    CLR_N = 1'b1; D = 8'h00; LD = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      ean  = (dig == 0) ? 2'b10 : 2'b11;
      eseg = (dig == 0) ? 7'h40 : 7'h7F;
      checks++;
      if (AN !== ean || SEG !== eseg || ERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_release edge %0d: AN=%b SEG=%h ERR=%b expected AN=%b SEG=%h ERR=0", cur, AN, SEG, ERR, ean, eseg);
      end
    end
  endtask

  task automatic test_latch_hold();
    logic [1:0] ean;
    logic [6:0] eseg;
    D = 8'h47; LD = 1'b1;
    tick();
    LD = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) D = 8'h12;
      tick();
      ean  = (dig == 0) ? 2'b10 : 2'b01;
      eseg = (dig == 0) ? 7'h78 : 7'h19;
      checks++;
      if (AN !== ean || SEG !== eseg) begin
        errors++;
        $display("FAIL latch_hold step %0d: AN=%b SEG=%h expected AN=%b SEG=%h", i, AN, SEG, ean, eseg);
      end
    end
  endtask

  task automatic test_counter();
    logic [7:0] cnt;
    logic [7:0] lq;
    logic [3:0] nib;
    logic [1:0] ean;
    logic [6:0] eseg;
    logic       wrapped;
    cnt = 8'h00; lq = 8'h47; LD = 1'b1; wrapped = 1'b0;
    for (int i = 0; i < 210; i++) begin
      D = cnt;
      tick();
      nib = (dig == 1) ? lq[7:4] : lq[3:0];
      if (dig == 1 && lq[7:4] == 4'd0) begin
        ean = 2'b11; eseg = 7'h7F;
      end else begin
        ean = (dig == 1) ? 2'b01 : 2'b10; eseg = seg_tab[nib];
      end
      checks++;
      if (AN !== ean || SEG !== eseg || ERR !== 1'b0) begin
        errors++;
        $display("FAIL counter step %0d L=%h: AN=%b SEG=%h ERR=%b expected AN=%b SEG=%h ERR=0", i, lq, AN, SEG, ERR, ean, eseg);
      end
      lq = cnt;
      if (i % 2 == 1) begin
        if (cnt[3:0] == 4'd9) begin
          cnt[3:0] = 4'd0;
          cnt[7:4] = (cnt[7:4] == 4'd9) ? 4'd0 : cnt[7:4] + 4'd1;
          if (cnt == 8'h00) wrapped = 1'b1;
        end else begin
          cnt[3:0] = cnt[3:0] + 4'd1;
        end
      end
    end
    checks++;
    if (wrapped !== 1'b1) begin
      errors++;
      $display("FAIL counter_wrap: wrapped=%b expected 1", wrapped);
    end
  endtask

  task automatic test_nonbcd();
    logic [1:0] ean;
    logic [6:0] eseg;
    D = 8'h0A; LD = 1'b1;
    tick();
    tick();
    checks++;
    if (ERR !== 1'b1) begin
      errors++;
      $display("FAIL nonbcd_err_latency: ERR=%b expected 1", ERR);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      ean  = (dig == 0) ? 2'b10 : 2'b11;
      eseg = (dig == 0) ? 7'h3F : 7'h7F;
      checks++;
      if (AN !== ean || SEG !== eseg || ERR !== 1'b1) begin
        errors++;
        $display("FAIL nonbcd step %0d: AN=%b SEG=%h ERR=%b expected AN=%b SEG=%h ERR=1", i, AN, SEG, ERR, ean, eseg);
      end
    end
  endtask

  task automatic test_blank_off();
    logic [1:0] ean;
    logic [6:0] eseg;
    D = 8'h05; LD = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      ean  = (dig == 0) ? 2'b10 : 2'b01;
      eseg = (dig == 0) ? 7'h12 : 7'h40;
      checks++;
      if (AN_NB !== ean || SEG_NB !== eseg || ERR_NB !== 1'b0) begin
        errors++;
        $display("FAIL blank_off step %0d: AN=%b SEG=%h ERR=%b expected AN=%b SEG=%h ERR=0", i, AN_NB, SEG_NB, ERR_NB, ean, eseg);
      end
      ean  = (dig == 0) ? 2'b10 : 2'b11;
      eseg = (dig == 0) ? 7'h12 : 7'h7F;
      checks++;
      if (AN !== ean || SEG !== eseg) begin
        errors++;
        $display("FAIL blank_on_05 step %0d: AN=%b SEG=%h expected AN=%b SEG=%h", i, AN, SEG, ean, eseg);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] ean;
    logic [6:0] eseg;
    int         budget;
    budget = 0;
    LD = 1'b0;
    while (!(dig == 1 && (cur % 4) == 1) && budget < 16) begin
      tick();
      budget++;
    end
    checks++;
    if (budget >= 16) begin
      errors++;
      $display("FAIL reset_mid_align: no digit-1 dwell found in %0d cycles, expected within 16", budget);
    end
    CLR_N = 1'b0; LD = 1'b1; D = 8'h99;
    tick();
    checks++;
    if (AN !== 2'b11 || SEG !== 7'h7F || ERR !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: AN=%b SEG=%h ERR=%b expected AN=11 SEG=7f ERR=0", AN, SEG, ERR);
    end
    CLR_N = 1'b1; LD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      ean  = (i < 4) ? 2'b10 : 2'b11;
      eseg = (i < 4) ? 7'h40 : 7'h7F;
      checks++;
      if (AN !== ean || SEG !== eseg || ERR !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_restart step %0d: AN=%b SEG=%h ERR=%b expected AN=%b SEG=%h ERR=0", i, AN, SEG, ERR, ean, eseg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latch_hold();
    test_counter();
    test_nonbcd();
    test_blank_off();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
